// File: rtl/pulse_acq_controller.sv
// Run-control sequencer around level_trigger_integrator: snapshots config, flushes the integrator, gates samples, counts/tags sums.
// Latency: zero-cycle combinational pass-through on both streams in RUN; control decisions take effect on the next cycle.
// Backpressure: in RUN ready/valid pass straight through; outside RUN both inputs are always ready and their beats are dropped.
// Optional idle timeout is compiled in when PULSE_ACQ_TIMEOUT_EN is defined.
module pulse_acq_controller #(
  parameter int WIDTH         = 16,
  parameter int SUM_WIDTH     = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int FLUSH_CYCLES  = 4,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         cfg_trigger_level,
  input  logic [1:0]               cfg_trigger_enable,
  input  logic [COUNT_WIDTH-1:0]   cfg_pulse_count,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     timed_out,
  output logic [COUNT_WIDTH-1:0]   sums_accepted,
  output logic                     int_resetn,
  output logic [WIDTH-1:0]         int_trigger_level,
  output logic [1:0]               int_trigger_enable,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [WIDTH-1:0]         s_tdata,
  output logic                     g_tvalid,
  input  logic                     g_tready,
  output logic [WIDTH-1:0]         g_tdata,
  input  logic                     i_tvalid,
  output logic                     i_tready,
  input  logic [SUM_WIDTH-1:0]     i_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [SUM_WIDTH-1:0]     m_tdata,
  output logic                     m_tlast
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [FLUSH_W-1:0]     flush_cnt;
  logic [COUNT_WIDTH-1:0] pulse_count;
  logic                   rst_pulse;

  logic in_run;
  logic start_ok;
  logic m_hs;
  logic last_beat;
  logic tlast_hs;
  logic abort_hit;
  logic timeout_hit;

  assign in_run    = (state == ST_RUN);
  assign start_ok  = (state == ST_IDLE) && start;
  assign m_hs      = in_run && i_tvalid && m_tready;
  // Count 0 means continuous: never tag a beat as last.
  assign last_beat = (pulse_count != '0) &&
                     ((sums_accepted + COUNT_WIDTH'(1)) == pulse_count);
  assign tlast_hs  = m_hs && last_beat;
  // A completing tlast beat outranks a coincident abort.
  assign abort_hit = abort && ((state == ST_FLUSH) || (in_run && !tlast_hs));

`ifdef PULSE_ACQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;

  assign timeout_hit = in_run && !m_hs && (cfg_timeout != '0) &&
                       ((idle_cnt + TIMEOUT_WIDTH'(1)) == cfg_timeout);

  // Idle counter: cycles in RUN since entry or since the last accepted sum.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (!in_run || m_hs) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TIMEOUT_WIDTH'(1);
    end
  end

  // Sticky timeout cause; abort and tlast take precedence when coincident.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timed_out <= 1'b0;
    end else if (start_ok) begin
      timed_out <= 1'b0;
    end else if (timeout_hit && !abort_hit) begin
      timed_out <= 1'b1;
    end
  end
`else
  logic unused_cfg_timeout;

  assign unused_cfg_timeout = ^cfg_timeout;
  assign timeout_hit        = 1'b0;
  assign timed_out          = 1'b0;
`endif

  // Next-state selection for the run sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (abort)                        state_nxt = ST_DRAIN;
        else if (flush_cnt == FLUSH_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (tlast_hs)                  state_nxt = ST_DONE;
        else if (abort || timeout_hit) state_nxt = ST_DRAIN;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush length counter; restarts from zero every time FLUSH is entered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      flush_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      flush_cnt <= flush_cnt + FLUSH_W'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  // One-cycle integrator reset after our own reset releases.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_pulse <= 1'b1;
    end else begin
      rst_pulse <= 1'b0;
    end
  end

  // Config snapshot taken on an accepted start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_trigger_level  <= '0;
      int_trigger_enable <= '0;
      pulse_count        <= '0;
    end else if (start_ok) begin
      int_trigger_level  <= cfg_trigger_level;
      int_trigger_enable <= cfg_trigger_enable;
      pulse_count        <= cfg_pulse_count;
    end
  end

  // Accepted-sum counter; wraps naturally in continuous mode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sums_accepted <= '0;
    end else if (start_ok) begin
      sums_accepted <= '0;
    end else if (m_hs) begin
      sums_accepted <= sums_accepted + COUNT_WIDTH'(1);
    end
  end

  // Sticky abort cause, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aborted <= 1'b0;
    end else if (start_ok) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end

  // Stream gating and status decode.
  always_comb begin
    g_tvalid   = in_run && s_tvalid;
    s_tready   = in_run ? g_tready : 1'b1;
    g_tdata    = s_tdata;
    m_tvalid   = in_run && i_tvalid;
    i_tready   = in_run ? m_tready : 1'b1;
    m_tdata    = i_tdata;
    m_tlast    = in_run && last_beat;
    busy       = (state == ST_FLUSH) || (state == ST_RUN) || (state == ST_DRAIN);
    done       = (state == ST_DONE) || (state == ST_DRAIN);
    int_resetn = !(rst_pulse || (state == ST_FLUSH) || (state == ST_DRAIN));
  end

endmodule

// File: tb/tb_pulse_acq_controller.sv
// Directed bench for pulse_acq_controller with a cycle-indexed run model and per-cycle compare.
module tb_pulse_acq_controller;
  localparam int W  = 16;
  localparam int SW = 32;
  localparam int CW = 16;
  localparam int FC = 4;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          resetn, start, abort;
  logic [W-1:0]  cfg_trigger_level;
  logic [1:0]    cfg_trigger_enable;
  logic [CW-1:0] cfg_pulse_count;
  logic [TW-1:0] cfg_timeout;
  logic          busy, done, aborted, timed_out;
  logic [CW-1:0] sums_accepted;
  logic          int_resetn;
  logic [W-1:0]  int_trigger_level;
  logic [1:0]    int_trigger_enable;
  logic          s_tvalid, s_tready, g_tvalid, g_tready;
  logic [W-1:0]  s_tdata, g_tdata;
  logic          i_tvalid, i_tready, m_tvalid, m_tready, m_tlast;
  logic [SW-1:0] i_tdata, m_tdata;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic i_en     = 1'b0;
  logic tog      = 1'b0;
  int   sum_base = 0;
  logic i_hs_q   = 1'b0;

  // run model: cycle indices of the run, count of accepted beats, sticky causes
  logic          mdl_active    = 1'b0;
  int            mdl_run_begin = 0;
  int            mdl_done_cyc  = -1;
  logic          mdl_drain_end = 1'b0;
  logic [CW-1:0] mdl_beats     = '0;
  logic [CW-1:0] mdl_cnt       = '0;
  logic          mdl_abt       = 1'b0;
  logic          mdl_tmo       = 1'b0;
  logic          mdl_post_rst  = 1'b1;
  int            mdl_last_ref  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_acq_controller #(
    .WIDTH(W), .SUM_WIDTH(SW), .COUNT_WIDTH(CW), .FLUSH_CYCLES(FC), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_trigger_level(cfg_trigger_level), .cfg_trigger_enable(cfg_trigger_enable),
    .cfg_pulse_count(cfg_pulse_count), .cfg_timeout(cfg_timeout),
    .busy(busy), .done(done), .aborted(aborted), .timed_out(timed_out),
    .sums_accepted(sums_accepted), .int_resetn(int_resetn),
    .int_trigger_level(int_trigger_level), .int_trigger_enable(int_trigger_enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .g_tvalid(g_tvalid), .g_tready(g_tready), .g_tdata(g_tdata),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stream drivers: sums are numbered sum_base+1, +2, ... and advance only on an i handshake.
  initial begin : drive_streams
    int sum_idx;
    sum_idx  = 0;
    i_tvalid = 1'b0; i_tdata = '0; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; g_tready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (!i_en) sum_idx = 0;
      else if (i_hs_q) sum_idx++;
      i_tvalid = i_en;
      i_tdata  = SW'(sum_base + sum_idx + 1);
      m_tready = tog ? cyc[0] : 1'b1;
      s_tvalid = cyc[1];
      s_tdata  = W'(cyc * 3);
      g_tready = ~cyc[2];
    end
  end

  // Per-cycle compare against the run model, then advance the model.
  initial begin : compare
    logic in_run, hs, last_exp;
    forever begin
      @(negedge clk);
      i_hs_q = i_tvalid && i_tready;
      if (!resetn) begin
        mdl_active = 1'b0; mdl_done_cyc = -1; mdl_beats = '0;
        mdl_abt = 1'b0; mdl_tmo = 1'b0; mdl_post_rst = 1'b1;
      end else begin
        in_run   = mdl_active && (cyc >= mdl_run_begin);
        hs       = in_run && i_tvalid && m_tready;
        last_exp = (mdl_cnt != '0) && (CW'(mdl_beats + 1) == mdl_cnt);
        chk("busy", busy, mdl_active || (cyc == mdl_done_cyc && mdl_drain_end));
        chk("done", done, cyc == mdl_done_cyc);
        chk("int_resetn", int_resetn, !(mdl_post_rst || (mdl_active && cyc < mdl_run_begin) ||
                                        (cyc == mdl_done_cyc && mdl_drain_end)));
        chk("sums_accepted", sums_accepted, mdl_beats);
        chk("aborted", aborted, mdl_abt);
        chk("timed_out", timed_out, mdl_tmo);
        if (in_run) begin
          chk("m_tvalid_pass", m_tvalid, i_tvalid);
          chk("i_tready_pass", i_tready, m_tready);
          chk("g_tvalid_pass", g_tvalid, s_tvalid);
          chk("s_tready_pass", s_tready, g_tready);
          if (s_tvalid) chk("g_tdata", g_tdata, s_tdata);
          if (i_tvalid) chk("m_tlast", m_tlast, last_exp);
          if (hs) chk("m_tdata", m_tdata, SW'(sum_base + int'(mdl_beats) + 1));
        end else begin
          chk("m_tvalid_gated", m_tvalid, 1'b0);
          chk("i_tready_gated", i_tready, 1'b1);
          chk("g_tvalid_gated", g_tvalid, 1'b0);
          chk("s_tready_gated", s_tready, 1'b1);
        end
        mdl_post_rst = 1'b0;
        if (hs) mdl_beats = mdl_beats + 1'b1;
        if (!mdl_active && start && cyc != mdl_done_cyc) begin
          mdl_active = 1'b1; mdl_run_begin = cyc + 1 + FC; mdl_last_ref = cyc + 1 + FC;
          mdl_beats = '0; mdl_cnt = cfg_pulse_count; mdl_abt = 1'b0; mdl_tmo = 1'b0;
        end else if (hs && last_exp) begin
          mdl_active = 1'b0; mdl_done_cyc = cyc + 1; mdl_drain_end = 1'b0;
        end else if (mdl_active && abort) begin
          mdl_active = 1'b0; mdl_done_cyc = cyc + 1; mdl_drain_end = 1'b1; mdl_abt = 1'b1;
        end
`ifdef PULSE_ACQ_TIMEOUT_EN
        else if (in_run && !hs && cfg_timeout != '0 &&
                 (cyc - mdl_last_ref + 1) == int'(cfg_timeout)) begin
          mdl_active = 1'b0; mdl_done_cyc = cyc + 1; mdl_drain_end = 1'b1; mdl_tmo = 1'b1;
        end
`endif
        if (hs) mdl_last_ref = cyc + 1;
      end
    end
  end

  task automatic start_run(input logic [W-1:0] lvl, input logic [1:0] en, input logic [CW-1:0] cnt,
                           input logic feed, input int base, output int lowc, output int run_cyc);
    @(posedge clk); #1;
    cfg_trigger_level = lvl; cfg_trigger_enable = en; cfg_pulse_count = cnt;
    sum_base = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_trigger_level = ~lvl; cfg_trigger_enable = ~en; cfg_pulse_count = cnt + 16'd7;
    lowc = 0;
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      if (!int_resetn) lowc++;
    end
    i_en = feed;
    @(negedge clk);
    if (!int_resetn) lowc++;
    run_cyc = cyc;
  endtask

  task automatic wait_done(input int bound, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: done not seen within %0d cycles", nm, bound);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lowc, rc, done_cnt, rise;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_trigger_level = '0; cfg_trigger_enable = '0; cfg_pulse_count = '0; cfg_timeout = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_int_resetn_low", int_resetn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sums", sums_accepted, 16'd0);
    chk("rst_level", int_trigger_level, 16'd0);
    @(negedge clk);
    chk("rst_int_resetn_high", int_resetn, 1'b1);

    // 1: three sums, tlast on the third
    start_run(16'd100, 2'b01, 16'd3, 1'b1, 1000, lowc, rc);
    chk("t1_flush_low_cycles", lowc, 4);
    chk("t1_level_latched", int_trigger_level, 16'd100);
    chk("t1_enable_latched", int_trigger_enable, 2'b01);
    chk("t1_busy_run", busy, 1'b1);
    wait_done(20, "t1_done");
    chk("t1_done_cycle", cyc - rc, 3);
    @(posedge clk); #1 i_en = 1'b0;
    @(negedge clk);
    chk("t1_sums", sums_accepted, 16'd3);
    chk("t1_model_beats", mdl_beats, 16'd3);
    chk("t1_busy_idle", busy, 1'b0);

    // 2: m_tready toggling, five sums
    tog = 1'b1;
    start_run(16'd200, 2'b10, 16'd5, 1'b1, 2000, lowc, rc);
    wait_done(60, "t2_done");
    @(posedge clk); #1 i_en = 1'b0; tog = 1'b0;
    @(negedge clk);
    chk("t2_sums", sums_accepted, 16'd5);
    chk("t2_aborted", aborted, 1'b0);

    // 3: continuous mode, ten sums then abort
    start_run(16'd50, 2'b11, 16'd0, 1'b1, 3000, lowc, rc);
    for (int k = 0; k < 100 && mdl_beats != 16'd10; k++) begin
      @(posedge clk); #1;
    end
    i_en = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(10, "t3_done");
    @(negedge clk);
    chk("t3_sums", sums_accepted, 16'd10);
    chk("t3_aborted", aborted, 1'b1);
    chk("t3_busy", busy, 1'b0);

    // 4: abort coincides with the tlast handshake
    start_run(16'd70, 2'b01, 16'd2, 1'b1, 4000, lowc, rc);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(10, "t4_done");
    @(posedge clk); #1 i_en = 1'b0;
    @(negedge clk);
    chk("t4_sums", sums_accepted, 16'd2);
    chk("t4_aborted", aborted, 1'b0);
    chk("t3_flag_cleared_by_start", aborted, 1'b0);

    // 5: idle timeout
    cfg_timeout = 32'd50;
    start_run(16'd10, 2'b01, 16'd0, 1'b0, 5000, lowc, rc);
`ifdef PULSE_ACQ_TIMEOUT_EN
    rise = -1;
    for (int k = 0; k < 100 && rise < 0; k++) begin
      @(negedge clk);
      if (timed_out) rise = cyc;
    end
    chk("t5_timeout_delay", rise - rc, 50);
    chk("t5_done_with_timeout", done, 1'b1);
    chk("t5_aborted", aborted, 1'b0);
`else
    rise = 0;
    repeat (60) @(negedge clk);
    chk("t5_timed_out_tied", timed_out, 1'b0);
    chk("t5_still_busy", busy, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(10, "t5_done");
`endif
    cfg_timeout = '0;
    @(negedge clk);
    chk("t5_idle", busy, 1'b0);

    // 6: start while busy is ignored; reset mid-run gives no done
    start_run(16'd300, 2'b11, 16'd0, 1'b1, 6000, lowc, rc);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; cfg_trigger_level = 16'd999;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_start", busy, 1'b1);
    chk("t6_level_kept", int_trigger_level, 16'd300);
    @(posedge clk); #1 resetn = 1'b0; i_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    chk("t6_int_resetn_pulse", int_resetn, 1'b0);
    chk("t6_busy_after_reset", busy, 1'b0);
    chk("t6_sums_after_reset", sums_accepted, 16'd0);
    if (done) done_cnt++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("t6_no_done", done_cnt, 0);
    chk("t6_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
